// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
// Holds the IF state encoding, word width, PC increment and slot helper.
package legv8_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    // A new request may only go out when the IF/ID slot is empty or being drained this cycle.
    function automatic logic slot_free(input logic valid, input logic stall);
        return !valid || !stall;
    endfunction

endpackage

// File: rtl/legv8_pc_reg.sv
// Program counter with +4 increment and word-aligned redirect.
// Redirect has priority over advance; the PC is reset asynchronously to RESET_PC.
module legv8_pc_reg
    import legv8_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] INC      = PC_W'(PC_INC);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(PC_INC - 1);

    logic [PC_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target & ~LOW_MASK;
        end else if (advance) begin
            pc_next = pc + INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/legv8_if_stage.sv
// LEGv8 instruction-fetch stage: single-outstanding imem requests feeding the IF/ID slot.
// Build option: define LEGV8_IF_FETCH_CNT_EN to add the fetch_cnt consumed-instruction counter.
module legv8_if_stage
    import legv8_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc
`ifdef LEGV8_IF_FETCH_CNT_EN
   ,output logic [31:0]       fetch_cnt
`endif
);

    if_state_e       state;
    if_state_e       state_next;
    logic [PC_W-1:0] pc;
    logic            issue;
    logic            accept;
    logic            slot_take;

    assign slot_take = if_valid && !id_stall;
    assign issue     = (state == FETCH) && slot_free(if_valid, id_stall) && !br_taken;
    assign accept    = (state == WAIT) && imem_rvalid && !br_taken;

    // The request is combinational so it goes out the first cycle after reset release.
    assign imem_req  = issue && !rst;
    assign imem_addr = imem_req ? pc : '0;

    legv8_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .advance  (accept),
        .redirect (br_taken),
        .target   (br_target),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (issue) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end else if (br_taken) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Redirect wins over both a landing response and a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_inst  <= '0;
            if_pc    <= '0;
        end else if (br_taken) begin
            if_valid <= 1'b0;
        end else if (accept) begin
            if_valid <= 1'b1;
            if_inst  <= imem_rdata;
            if_pc    <= pc;
        end else if (slot_take) begin
            if_valid <= 1'b0;
        end
    end

`ifdef LEGV8_IF_FETCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if (slot_take && !br_taken) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_if_stage.sv
// Bench for legv8_if_stage: directed scenarios plus random stall/redirect/latency traffic,
// checked against a transaction-level model of fetch order and slot contents.
module tb_legv8_if_stage;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
`ifdef LEGV8_IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    legv8_if_stage #(
        .PC_W     (64),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .id_stall    (id_stall),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc)
`ifdef LEGV8_IF_FETCH_CNT_EN
       ,.fetch_cnt   (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: expected slot, outstanding request, next program-order fetch address.
    logic        m_valid;
    logic [31:0] m_inst;
    logic [63:0] m_pc;
    logic        m_out;
    logic        m_kill;
    logic [63:0] m_req_addr;
    logic [63:0] m_next;
    int unsigned m_cnt;

    // Memory responder.
    logic        mb_busy;
    int          mb_cnt;
    logic [63:0] mb_addr;
    int          mem_lat;
    logic        lat_rand;
    logic        inject_stale;

    logic        o_req;
    logic [63:0] o_addr;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [63:0] o_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B020020;
        if (a == 64'h4) return 32'hCB030041;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_inst = '0; m_pc = '0;
        m_out = 1'b0; m_kill = 1'b0; m_req_addr = '0;
        m_next = RST_PC; m_cnt = 0;
        mb_busy = 1'b0; mb_cnt = 0; mb_addr = '0;
    endtask

    // One clock: called at a negedge, drives inputs, checks, advances the model, ends at next negedge.
    task automatic step(input logic stall, input logic br, input logic [63:0] tgt);
        logic resp;
        logic req_exp;
        logic take;
        resp = mb_busy && (mb_cnt == 1);
        id_stall  = stall;
        br_taken  = br;
        br_target = tgt;
        if (resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(mb_addr);
        end else if (inject_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEADBEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        inject_stale = 1'b0;
        #1;
        o_req = imem_req; o_addr = imem_addr;
        o_valid = if_valid; o_inst = if_inst; o_pc = if_pc;

        req_exp = !m_out && (!m_valid || !stall) && !br;
        chk("imem_req", o_req, req_exp);
        if (req_exp) chk("imem_addr", o_addr, m_next);
        chk("if_valid", o_valid, m_valid);
        if (m_valid) begin
            chk("if_pc", o_pc, m_pc);
            chk("if_inst", o_inst, m_inst);
        end
`ifdef LEGV8_IF_FETCH_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_cnt);
`endif

        take = m_valid && !stall;
        if (take && !br) m_cnt++;
        if (br) begin
            m_valid = 1'b0;
            m_next  = tgt & ~64'h3;
            if (m_out) m_kill = 1'b1;
        end else if (imem_rvalid && m_out && !m_kill) begin
            m_valid = 1'b1;
            m_inst  = imem_rdata;
            m_pc    = m_req_addr;
        end else if (take) begin
            m_valid = 1'b0;
        end
        if (imem_rvalid && m_out) m_out = 1'b0;
        if (req_exp) begin
            m_out = 1'b1; m_kill = 1'b0;
            m_req_addr = m_next;
            m_next = m_next + 64'd4;
        end

        if (resp) mb_busy = 1'b0;
        else if (mb_busy) mb_cnt--;
        if (o_req && !mb_busy) begin
            mb_busy = 1'b1;
            mb_addr = o_addr;
            mb_cnt  = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_rvalid = 1'b0; br_taken = 1'b0; id_stall = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 64'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_req", imem_req, 1'b0);
            chk("rst_hold_valid", if_valid, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [63:0] tgt;
        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
        inject_stale = 1'b0; lat_rand = 1'b0; mem_lat = 1;
        model_reset();
        @(negedge clk);

        // Reset and sequential fetch from RESET_PC with 1-cycle memory.
        do_reset();
        step(0, 0, 0);
        chk("t1_req", o_req, 1'b1);
        chk("t1_addr", o_addr, 64'h0);
        step(0, 0, 0);
        chk("t2_c1_valid", o_valid, 1'b0);
        step(0, 0, 0);
        chk("t2_c2_valid", o_valid, 1'b1);
        chk("t2_c2_pc", o_pc, 64'h0);
        chk("t2_c2_inst", o_inst, 32'h8B020020);
        step(0, 0, 0);
        chk("t2_c3_valid", o_valid, 1'b0);

        // Stall for 3 cycles on the second instruction.
        for (int unsigned i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("t3_valid", o_valid, 1'b1);
            chk("t3_pc", o_pc, 64'h4);
            chk("t3_inst", o_inst, 32'hCB030041);
            chk("t3_req", o_req, 1'b0);
        end
        mem_lat = 2;
        step(0, 0, 0);
        chk("t3_resume_req", o_req, 1'b1);
        chk("t3_resume_addr", o_addr, 64'h8);

        // Redirect while waiting; the late response must be dropped.
        step(0, 1, 64'h103);
        chk("t4_req", o_req, 1'b0);
        mem_lat = 1;
        step(0, 0, 0);
        chk("t4_stale_valid", o_valid, 1'b0);
        chk("t4_drain_req", o_req, 1'b0);
        step(0, 0, 0);
        chk("t4_valid", o_valid, 1'b0);
        chk("t4_req_target", o_req, 1'b1);
        chk("t4_addr_target", o_addr, 64'h100);
        step(0, 0, 0);

        // Redirect overrides a stalled valid slot.
        step(1, 1, 64'h200);
        chk("t5_valid_before", o_valid, 1'b1);
        chk("t5_pc_before", o_pc, 64'h100);
        step(1, 0, 0);
        chk("t5_valid_after", o_valid, 1'b0);
        chk("t5_req", o_req, 1'b1);
        chk("t5_addr", o_addr, 64'h200);

        // Random traffic: stalls, redirects (some near address wrap) and variable latency.
        lat_rand = 1'b1;
        for (int unsigned i = 0; i < 600; i++) begin
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF7;
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), tgt);
        end

        // Async reset while a request is outstanding, then a stale response after release.
        lat_rand = 1'b0; mem_lat = 3;
        got = 1'b0;
        for (int unsigned i = 0; i < 20 && !got; i++) begin
            step(0, 0, 0);
            got = o_req;
        end
        chk("t6_reached_wait", got, 1'b1);
        imem_rvalid = 1'b0;
        #2;
        do_reset();
        mem_lat = 1;
        inject_stale = 1'b1;
        step(0, 0, 0);
        chk("t6_req", o_req, 1'b1);
        chk("t6_addr", o_addr, RST_PC);
        step(0, 0, 0);
        chk("t6_stale_dropped", o_valid, 1'b0);
        step(0, 0, 0);
        chk("t6_valid", o_valid, 1'b1);
        chk("t6_inst", o_inst, 32'h8B020020);

`ifdef LEGV8_IF_FETCH_CNT_EN
        for (int unsigned i = 0; i < 40 && m_cnt < 5; i++) begin
            step(0, 0, 0);
        end
        chk("t6_fetch_cnt", fetch_cnt, 32'd5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
